// File: rtl/defines_pkg.sv
// Shared types and constants for the local-store DMA engine.
package defines_pkg;

  localparam int QW_BYTES     = 16;
  localparam int LS_BYTES_DEF = 262144;
  localparam int MAX_QW       = 1024;

  typedef enum logic { DIR_GET = 1'b0, DIR_PUT = 1'b1 } DmaDir;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GET   = 2'd1,
    ST_PUT   = 2'd2,
    ST_DRAIN = 2'd3
  } DmaState;

endpackage

// File: rtl/dma_skid_fifo.sv
// Two-entry valid/ready buffer between LS read returns and the PUT stream.
module dma_skid_fifo #(
  parameter int W = 128
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data,
  output logic [1:0]   count
);

  logic [1:0][W-1:0] mem;
  logic              wr_ptr, rd_ptr;
  logic              push, pop;

  assign in_ready  = (count != 2'd2);
  assign out_valid = (count != 2'd0);
  assign out_data  = mem[rd_ptr];
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= in_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      count <= count + {1'b0, push} - {1'b0, pop};
    end
  end

endmodule

// File: rtl/ls_dma_engine.sv
// Local-store DMA engine: GET streams quadwords into LS, PUT streams LS out
// through a skid buffer. Addresses wrap modulo LS_BYTES.
module ls_dma_engine
  import defines_pkg::*;
#(
  parameter int LEN_W    = 11,
  parameter int LS_BYTES = LS_BYTES_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_dir,
  input  logic [31:0]      cmd_ls_addr,
  input  logic [LEN_W-1:0] cmd_len,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [127:0]     in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [127:0]     out_data,
  output logic             ls_req,
  input  logic             ls_gnt,
  output logic [31:0]      ls_addr,
  output logic             ls_wr_en,
  output logic [127:0]     ls_data_wr,
  input  logic [127:0]     ls_data_rd,
  output logic             busy,
  output logic             done,
  output logic             err
);

  localparam logic [31:0] ADDR_MASK = 32'(LS_BYTES - 1);

  DmaState          state, state_nxt;
  logic [31:0]      addr;
  logic [LEN_W-1:0] cnt;
  logic             rd_pend, done_q, err_q;
  logic             cmd_fire, cmd_bad, wr_fire, rd_fire;

  logic             sk_ready, sk_valid, sk_pop;
  logic [127:0]     sk_data;
  logic [1:0]       sk_cnt;

  assign cmd_bad = (cmd_len == '0) || (32'(cmd_len) > 32'(MAX_QW)) ||
                   (cmd_ls_addr[3:0] != 4'h0);
  assign sk_pop  = sk_valid & out_ready;

  always_comb begin
    state_nxt = state;
    cmd_fire  = 1'b0;
    wr_fire   = 1'b0;
    rd_fire   = 1'b0;
    case (state)
      ST_IDLE: begin
        cmd_fire = cmd_valid;
        if (cmd_valid && !cmd_bad)
          state_nxt = (DmaDir'(cmd_dir) == DIR_PUT) ? ST_PUT : ST_GET;
      end
      ST_GET: begin
        wr_fire = in_valid & ls_gnt;
        if (wr_fire && cnt == LEN_W'(1)) state_nxt = ST_IDLE;
      end
      ST_PUT: begin
        // In-flight read plus buffered data never exceeds the skid depth.
        rd_fire = ls_gnt && sk_ready && (({1'b0, rd_pend} + sk_cnt) < 2'd2);
        if (rd_fire && cnt == LEN_W'(1)) state_nxt = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (!rd_pend && sk_cnt == 2'd1 && sk_pop) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      addr    <= '0;
      cnt     <= '0;
      rd_pend <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state   <= state_nxt;
      rd_pend <= rd_fire;
      err_q   <= cmd_fire & cmd_bad;
      done_q  <= (state != ST_IDLE) && (state_nxt == ST_IDLE);
      if (cmd_fire && !cmd_bad) begin
        addr <= cmd_ls_addr & ADDR_MASK;
        cnt  <= cmd_len;
      end else if (wr_fire || rd_fire) begin
        addr <= (addr + 32'(QW_BYTES)) & ADDR_MASK;
        cnt  <= cnt - LEN_W'(1);
      end
    end
  end

  dma_skid_fifo #(.W(128)) u_skid (
    .clk      (clk),
    .rst      (rst),
    .in_valid (rd_pend),
    .in_ready (sk_ready),
    .in_data  (ls_data_rd),
    .out_valid(sk_valid),
    .out_ready(out_ready),
    .out_data (sk_data),
    .count    (sk_cnt)
  );

  // Everything is forced low while rst is held, even before the state clears.
  assign busy       = (state != ST_IDLE) & ~rst;
  assign cmd_ready  = (state == ST_IDLE) & ~rst;
  assign done       = done_q & ~rst;
  assign err        = err_q & ~rst;
  assign ls_req     = busy;
  assign ls_addr    = busy ? addr : '0;
  assign in_ready   = (state == ST_GET) & ls_gnt & ~rst;
  assign ls_wr_en   = wr_fire & ~rst;
  assign ls_data_wr = ((state == ST_GET) && !rst) ? in_data : '0;
  assign out_valid  = sk_valid & ~rst;
  assign out_data   = out_valid ? sk_data : '0;

endmodule

// File: doc/ls_dma_engine.md
LS_DMA_ENGINE -- requirements
Module: ls_dma_engine

Interface
REQ-001 Clocking and reset SHALL be one clock `clk`, with `rst` synchronous and active-high; all state SHALL update only on `clk` rising edge.
REQ-002 Parameter LEN_W, default 11: width of the quadword count (max transfer 1024 QW = 16 KB).
REQ-003 Parameter LS_BYTES, default 262144: local store size; addresses wrap modulo this value.
REQ-004 Ports SHALL be:
- clk  in  1  clock
- rst  in  1  sync active-high reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  engine accepts command
- cmd_dir  in  1  0=GET (ext->LS), 1=PUT (LS->ext)
- cmd_ls_addr  in  32  LS byte address, 16B aligned
- cmd_len  in  LEN_W  quadword count
- in_valid / in_ready / in_data  in/out/in  1/1/128  GET data stream
- out_valid / out_ready / out_data  out/in/out  1/1/128  PUT data stream
- ls_req  out  1  LS port request
- ls_gnt  in  1  LS port granted this cycle
- ls_addr  out  32  LS byte address
- ls_wr_en  out  1  LS write strobe
- ls_data_wr  out  128  LS write data
- ls_data_rd  in  128  LS read data, valid one cycle after a granted read
- busy  out  1  transfer in progress
- done  out  1  one-cycle completion pulse
- err  out  1  one-cycle rejected-command pulse

Function
REQ-005 FSM states SHALL be IDLE, GET, PUT, DRAIN; cmd_ready=1 only in IDLE.
REQ-006 Command acceptance (cmd_valid&cmd_ready) SHALL reject the command and pulse err next cycle, staying IDLE, if cmd_len==0, cmd_len>1024, or cmd_ls_addr[3:0]!=0 (LSB-numbered).
REQ-007 A valid command SHALL latch address and count, enter GET or PUT next cycle, and assert busy and ls_req until return to IDLE.
REQ-008 In GET: in_ready=ls_gnt; ls_wr_en=in_valid&ls_gnt; ls_data_wr=in_data; each write SHALL advance ls_addr by 16 and decrement the count.
REQ-009 In PUT: a read SHALL be issued (ls_gnt high, ls_wr_en low) only when issued-but-unconsumed reads plus skid occupancy <2; returned ls_data_rd SHALL enter a 2-entry skid buffer driving out_valid/out_data.
REQ-010 In PUT, after the last read issues, the FSM SHALL enter DRAIN and stay there until the skid buffer empties.
REQ-011 out_data order SHALL equal LS address order; no quadword is dropped or duplicated under any out_ready pattern.
REQ-012 ls_addr SHALL wrap from LS_BYTES-16 to 0; bits above log2(LS_BYTES) SHALL be 0.
REQ-013 done SHALL pulse the cycle after the final LS write (GET) or final out handshake (PUT); the FSM SHALL be in IDLE in that cycle.
REQ-014 Deasserting ls_gnt SHALL stall all LS accesses with no state loss; in_ready SHALL be 0 while ls_gnt=0.
REQ-015 A cmd_valid during busy SHALL be ignored (cmd_ready=0); a new command is accepted the cycle done is high.

Reset
REQ-016 Under rst the FSM SHALL go to IDLE, the skid buffer SHALL empty, and the count and address SHALL clear.
REQ-017 Outputs SHALL be 0 during and after rst (cmd_ready=1 from the first post-reset cycle).
REQ-018 A reset mid-transfer SHALL abandon it; LS writes already performed SHALL remain.

Structure
REQ-019 defines_pkg SHALL hold the DmaDir and DmaState enums plus QW_BYTES=16 and LS_BYTES_DEF=262144.
REQ-020 The skid buffer SHALL be the sub-module dma_skid_fifo (2 entries, 128 bits, valid/ready both sides).

Verification
REQ-021 GET addr 0x100, len 4, in_valid always 1, ls_gnt=1 -> writes to 0x100/110/120/130 on 4 consecutive cycles; done next cycle.
REQ-022 PUT addr 0x3FFF0, len 3, LS preloaded -> out_data order 0x3FFF0, 0x00000, 0x00010 (wrap), done after 3rd handshake.
REQ-023 PUT len 8, out_ready toggling 1/0 randomly, ls_gnt low 2 of every 5 cycles -> 8 quadwords in order, none lost or duplicated.
REQ-024 Commands len 0, len 1025, addr 0x104 -> err pulse each; no ls_req; FSM stays IDLE.
REQ-025 GET len 16 with rst asserted after 5 writes -> all outputs 0 next cycle, cmd_ready=1 after release, first 5 LS locations updated.
